// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the pipeline MEM
// stage (priority requester) and a secondary DMA master (loader/debug).
// A starvation counter forces a one-cycle DMA slot that stalls the pipeline.
module dmem_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              core_memread,
    input  logic              core_memwrite,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_memwrite,
    output logic              mem_memread,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic {
        OWN_CORE  = 1'b0,
        FORCE_DMA = 1'b1
    } state_t;

    localparam logic [3:0] LAST_DENY = 4'(STARVE_LIMIT - 1);

    state_t     state, state_next;
    logic [3:0] starve_cnt;
    logic       core_active;

    assign core_active = core_memread | core_memwrite;
    assign core_rdata  = mem_read_data;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= OWN_CORE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, memory steering and grant/stall; strobes gated while in reset
    always_comb begin
        state_next     = OWN_CORE;
        core_stall     = 1'b0;
        dma_gnt        = 1'b0;
        mem_memread    = 1'b0;
        mem_memwrite   = 1'b0;
        mem_address    = core_addr;
        mem_write_data = core_wdata;
        unique case (state)
            OWN_CORE: begin
                if (core_active) begin
                    mem_memread  = core_memread;
                    mem_memwrite = core_memwrite;
                    if (dma_req && starve_cnt == LAST_DENY) begin
                        state_next = FORCE_DMA;
                    end
                end else if (dma_req) begin
                    dma_gnt        = 1'b1;
                    mem_memread    = ~dma_we;
                    mem_memwrite   = dma_we;
                    mem_address    = dma_addr;
                    mem_write_data = dma_wdata;
                end
            end
            FORCE_DMA: begin
                core_stall     = 1'b1;
                dma_gnt        = dma_req;
                mem_memread    = dma_req & ~dma_we;
                mem_memwrite   = dma_req & dma_we;
                mem_address    = dma_addr;
                mem_write_data = dma_wdata;
            end
            default: ;
        endcase
        if (!reset_n) begin
            core_stall   = 1'b0;
            dma_gnt      = 1'b0;
            mem_memread  = 1'b0;
            mem_memwrite = 1'b0;
        end
    end

    // Count consecutive denied DMA cycles; any grant or dropped request restarts it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (dma_req && !dma_gnt) begin
            starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Capture DMA read data at the edge ending a granted read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
        end else begin
            dma_rvalid <= dma_gnt & ~dma_we;
            if (dma_gnt && !dma_we) begin
                dma_rdata <= mem_read_data;
            end
        end
    end

endmodule
